mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word memory behind a single-outstanding request/response handshake
// Each accepted request is answered exactly LATENCY+1 cycles later with a one-cycle response pulse.
module mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] read_data_o32,
  output logic        err_o
);

  localparam int         AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            live_q;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic            addr_err;
  logic            commit;
  logic            do_write;

  assign addr_err = (addr_i32[1:0] != 2'b00) || (addr_i32[31:AW+2] != '0);

  // The *_d request fields carry the live inputs on the accept edge and the
  // latched copy afterwards, so commit logic works even when LATENCY is zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && live_q) begin
          we_d    = req_we_i;
          err_d   = addr_err;
          idx_d   = addr_i32[AW+1:2];
          wdata_d = write_data_i32;
          if (LAT == 4'd0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT;
          end
        end
      end
      WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign commit   = (state_d == RESP) && (state_q != RESP);
  assign do_write = reset_i && commit && we_d && !err_d;

  always_comb begin
    rdata_d = rdata_q;
    if (commit) begin
      if (err_d)     rdata_d = 32'h0;
      else if (we_d) rdata_d = wdata_d;
      else           rdata_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      live_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage survives reset on purpose.
  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[idx_d] <= wdata_d;
  end

  assign req_ready_o   = (state_q == IDLE) && live_q;
  assign resp_valid_o  = (state_q == RESP);
  assign err_o         = (state_q == RESP) && err_q;
  assign read_data_o32 = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
// Three instances with different depth/latency, checked against a word-array model.
module tb_mem_responder;

  localparam int DEP [3] = '{16, 64, 64};
  localparam int LAT [3] = '{2, 0, 3};

  typedef struct {
    logic [31:0] data;
    bit          err;
    bit          chk;
    int          t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn [3];
  logic        vld  [3];
  logic        we   [3];
  logic [31:0] adr  [3];
  logic [31:0] wd   [3];
  logic        rdy  [3];
  logic        rv   [3];
  logic        er   [3];
  logic [31:0] rd   [3];

  logic [31:0] mdl     [3][64];
  bit          known   [3][64];
  logic [31:0] last_rd [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(16), .LATENCY(2)) u_dut0 (
    .clk_i(clk), .reset_i(rstn[0]), .req_valid_i(vld[0]), .req_we_i(we[0]),
    .addr_i32(adr[0]), .write_data_i32(wd[0]), .req_ready_o(rdy[0]),
    .resp_valid_o(rv[0]), .read_data_o32(rd[0]), .err_o(er[0]));

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut1 (
    .clk_i(clk), .reset_i(rstn[1]), .req_valid_i(vld[1]), .req_we_i(we[1]),
    .addr_i32(adr[1]), .write_data_i32(wd[1]), .req_ready_o(rdy[1]),
    .resp_valid_o(rv[1]), .read_data_o32(rd[1]), .err_o(er[1]));

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) u_dut2 (
    .clk_i(clk), .reset_i(rstn[2]), .req_valid_i(vld[2]), .req_we_i(we[2]),
    .addr_i32(adr[2]), .write_data_i32(wd[2]), .req_ready_o(rdy[2]),
    .resp_valid_o(rv[2]), .read_data_o32(rd[2]), .err_o(er[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit is_err(input int k, input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * DEP[k]));
  endfunction

  function automatic logic [31:0] rnd_addr(input int k);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = $urandom;
      1:       a = 32'(4 * DEP[k]) + 32'($urandom_range(0, 3) * 4);
      2:       a = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(1, 3));
      3:       a = 32'(4 * DEP[k] - 4);
      default: a = 32'($urandom_range(0, 7)) << 2;
    endcase
    return a;
  endfunction

  // Model lookup: expected response for a request given the current model contents.
  task automatic model_apply(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                             output exp_t x);
    int idx;
    x.err  = is_err(k, a);
    idx    = x.err ? 0 : int'(a >> 2);
    x.data = x.err ? 32'h0 : (w ? d : mdl[k][idx]);
    x.chk  = x.err || w || known[k][idx];
    x.t    = 0;
    if (w && !x.err) begin
      mdl[k][idx]   = d;
      known[k][idx] = 1'b1;
    end
  endtask

  // One isolated transaction; entered and left at a negedge with the DUT idle.
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input string tag);
    int   n;
    bit   bad_rdy, bad_hold;
    exp_t x;
    check({tag, ".ready_in"}, 32'(rdy[k]), 32'd1);
    vld[k] = 1'b1; we[k] = w; adr[k] = a; wd[k] = d;
    @(posedge clk);
    @(negedge clk);
    vld[k] = 1'b0;
    n = 1; bad_rdy = 1'b0; bad_hold = 1'b0;
    while (!rv[k] && n < 40) begin
      if (rdy[k]) bad_rdy = 1'b1;
      if (er[k] || rd[k] !== last_rd[k]) bad_hold = 1'b1;
      vld[k] = 1'($urandom); we[k] = 1'($urandom); adr[k] = $urandom; wd[k] = $urandom;
      @(negedge clk);
      n++;
    end
    vld[k] = 1'b0;
    if (rdy[k]) bad_rdy = 1'b1;
    check({tag, ".latency"}, 32'(n), 32'(LAT[k] + 1));
    check({tag, ".ready_busy"}, 32'(bad_rdy), 32'd0);
    check({tag, ".hold_wait"}, 32'(bad_hold), 32'd0);
    model_apply(k, w, a, d, x);
    check({tag, ".err"}, 32'(er[k]), 32'(x.err));
    if (x.chk) check({tag, ".data"}, rd[k], x.data);
    last_rd[k] = x.chk ? x.data : rd[k];
    @(negedge clk);
    check({tag, ".resp_end"}, 32'(rv[k]), 32'd0);
    check({tag, ".err_idle"}, 32'(er[k]), 32'd0);
    check({tag, ".ready_back"}, 32'(rdy[k]), 32'd1);
    check({tag, ".data_hold"}, rd[k], last_rd[k]);
  endtask

  // req_valid held high, inputs changing every cycle.
  task automatic stream(input int k, input int cycles, input string tag);
    exp_t        q[$];
    exp_t        x;
    int          last_acc;
    bit          w;
    logic [31:0] a, d;
    last_acc = -1;
    for (int t = 0; t < cycles + LAT[k] + 4; t++) begin
      if (rv[k]) begin
        if (q.size() == 0) begin
          check({tag, ".stray_resp"}, 32'd1, 32'd0);
        end else begin
          x = q.pop_front();
          check({tag, ".latency"}, 32'(t - x.t), 32'(LAT[k] + 1));
          check({tag, ".err"}, 32'(er[k]), 32'(x.err));
          if (x.chk) check({tag, ".data"}, rd[k], x.data);
          last_rd[k] = x.chk ? x.data : rd[k];
        end
      end else if (q.size() > 0 && t - q[0].t > LAT[k] + 1) begin
        check({tag, ".missing_resp"}, 32'd0, 32'd1);
        void'(q.pop_front());
      end
      if (t < cycles) begin
        w = 1'($urandom); a = rnd_addr(k); d = $urandom;
        vld[k] = 1'b1; we[k] = w; adr[k] = a; wd[k] = d;
        if (rdy[k]) begin
          if (last_acc >= 0) check({tag, ".gap"}, 32'(t - last_acc), 32'(LAT[k] + 2));
          last_acc = t;
          model_apply(k, w, a, d, x);
          x.t = t;
          q.push_back(x);
        end
      end else begin
        vld[k] = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, ".drained"}, 32'(q.size()), 32'd0);
  endtask

  task automatic abort_in_wait();
    bit bad;
    vld[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; wd[0] = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    vld[0] = 1'b0;
    rstn[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort.ready_rst", 32'(rdy[0]), 32'd0);
    check("abort.resp_rst", 32'(rv[0]), 32'd0);
    check("abort.err_rst", 32'(er[0]), 32'd0);
    check("abort.data_rst", rd[0], 32'h0);
    last_rd[0] = 32'h0;
    rstn[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort.ready_rel", 32'(rdy[0]), 32'd1);
    bad = 1'b0;
    repeat (6) begin
      if (rv[0]) bad = 1'b1;
      @(negedge clk);
    end
    check("abort.no_resp", 32'(bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      rstn[k] = 1'b0; vld[k] = 1'b0; we[k] = 1'b0; adr[k] = 32'h0; wd[k] = 32'h0;
      last_rd[k] = 32'h0;
      for (int i = 0; i < 64; i++) begin
        known[k][i] = 1'b0;
        mdl[k][i]   = 32'h0;
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d.ready", k), 32'(rdy[k]), 32'd0);
      check($sformatf("rst%0d.resp", k), 32'(rv[k]), 32'd0);
      check($sformatf("rst%0d.err", k), 32'(er[k]), 32'd0);
      check($sformatf("rst%0d.data", k), rd[k], 32'h0);
      rstn[k] = 1'b1;
    end
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("rel%0d.ready", k), 32'(rdy[k]), 32'd1);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, "wr10");
    txn(0, 1'b0, 32'h10, 32'h0,        "rd10");
    txn(0, 1'b1, 32'h00, 32'h11111111, "wr00");
    txn(0, 1'b0, 32'h13, 32'h0,        "rd13_err");
    txn(0, 1'b1, 32'h40, 32'hBAD0BAD0, "wr40_err");
    txn(0, 1'b0, 32'h00, 32'h0,        "rd00_prior");
    txn(0, 1'b0, 32'h10, 32'h0,        "rd10_prior");
    txn(0, 1'b1, 32'h3C, 32'hA5A5A5A5, "wr3c");
    txn(0, 1'b0, 32'h3C, 32'h0,        "rd3c");
    txn(0, 1'b0, 32'h40, 32'h0,        "rd40_err");
    txn(0, 1'b1, 32'h20, 32'h55,       "wr20");
    abort_in_wait();
    txn(0, 1'b0, 32'h20, 32'h0,        "rd20_after_abort");
    stream(0, 60, "stream0");

    txn(1, 1'b1, 32'h08, 32'hCAFEF00D, "l0_wr08");
    txn(1, 1'b0, 32'h08, 32'h0,        "l0_rd08");
    txn(1, 1'b0, 32'h100, 32'h0,       "l0_rd100_err");
    stream(1, 40, "stream1");
    repeat (30) txn(1, 1'($urandom), rnd_addr(1), $urandom, "rand1");

    repeat (60) txn(2, 1'($urandom), rnd_addr(2), $urandom, "rand2");
    stream(2, 80, "stream2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
